result_bank: RTL and testbench

- Output-side counterpart of the operand memory bank.
- The operand bank takes serial nibbles and presents them in parallel, 3 lanes, to the MAC array. This block does the reverse: it captures the parallel MAC result rows, one row of R = W*X per beat, into a 3x3 store.
- It then drains R serially, row-major, over a valid/ready handshake, one element per accepted beat.
- It sits between the MAC array and the accelerator's serial output port.

---
 rtl/result_bank_if.sv | 40 ++++
 rtl/result_bank.sv | 170 +++++++++++++++++
 tb/tb_result_bank.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/result_bank_if.sv
// ============================================================================
//  Module      : result_bank_if
//  Description : Bus bundle between the MAC array / serial output port and
//                the result bank. The master side drives result rows and the
//                downstream ready; the slave side (result_bank) returns the
//                serial stream and status.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface result_bank_if #(
    parameter int RES_W = 10,
    parameter int OUT_W = 8
);
    logic [RES_W-1:0] res_in1;
    logic [RES_W-1:0] res_in2;
    logic [RES_W-1:0] res_in3;
    logic             res_valid;
    logic [1:0]       row_w;
    logic [1:0]       col_x;
    logic             out_ready;
    logic [OUT_W-1:0] data_out;
    logic             data_valid;
    logic             last;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output res_in1, res_in2, res_in3, res_valid, row_w, col_x, out_ready,
        input  data_out, data_valid, last, busy, done, ovf
    );

    modport slave (
        input  res_in1, res_in2, res_in3, res_valid, row_w, col_x, out_ready,
        output data_out, data_valid, last, busy, done, ovf
    );
endinterface

`default_nettype wire

// File: rtl/result_bank.sv
// ============================================================================
//  Module      : result_bank
//  Description : Captures up to three parallel MAC result rows into a 3x3
//                store, then drains the rows_q x cols_q result serially,
//                row-major, over a valid/ready handshake.
//                Optional macro RESULT_BANK_SAT_EN: saturate entries that do
//                not fit in OUT_W bits instead of truncating them.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module result_bank #(
    parameter int RES_W = 10,
    parameter int OUT_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    result_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [RES_W-1:0] c_OUT_MAX = RES_W'({OUT_W{1'b1}});

    state_t           r_state;
    logic [1:0]       r_rows;
    logic [1:0]       r_cols;
    logic [1:0]       r_rc;
    logic [1:0]       r_ri;
    logic [1:0]       r_ci;
    logic [RES_W-1:0] r_store [0:8];
    logic [OUT_W-1:0] r_data;
    logic             r_valid;
    logic             r_last;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    logic             w_hs;
    logic             w_col_end;
    logic [1:0]       w_nri;
    logic [1:0]       w_nci;
    logic [3:0]       w_naddr;
    logic             w_nlast;
    logic [3:0]       w_wbase;

    // Narrow a stored entry to the output width (saturate or truncate).
    function automatic logic [OUT_W-1:0] f_fmt(input logic [RES_W-1:0] v);
`ifdef RESULT_BANK_SAT_EN
        if (v > c_OUT_MAX)
            return {OUT_W{1'b1}};
        else
            return v[OUT_W-1:0];
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    // Next element pointer and its store address; the pointer wraps at the
    // live column count, not at 3, so unused lanes are skipped.
    always_comb begin
        w_hs      = r_valid & bus.out_ready;
        w_col_end = (r_ci == r_cols - 2'd1);
        w_nri     = w_col_end ? r_ri + 2'd1 : r_ri;
        w_nci     = w_col_end ? 2'd0 : r_ci + 2'd1;
        w_naddr   = 4'(w_nri) * 4'd3 + 4'(w_nci);
        w_nlast   = (w_nri == r_rows - 2'd1) && (w_nci == r_cols - 2'd1);
        w_wbase   = 4'(r_rc) * 4'd3;
    end

    // Control FSM, result store and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rows  <= 2'd0;
            r_cols  <= 2'd0;
            r_rc    <= 2'd0;
            r_ri    <= 2'd0;
            r_ci    <= 2'd0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < 9; k++) r_store[k] <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Beats with a zero dimension are silently ignored.
                    if (bus.res_valid && bus.row_w != 2'd0 && bus.col_x != 2'd0) begin
                        r_rows     <= bus.row_w;
                        r_cols     <= bus.col_x;
                        r_store[0] <= bus.res_in1;
                        r_store[1] <= bus.res_in2;
                        r_store[2] <= bus.res_in3;
                        r_rc       <= 2'd1;
                        r_busy     <= 1'b1;
                        if (bus.row_w == 2'd1) begin
                            // Single row: entry (0,0) is being written now,
                            // so present it straight from the lane.
                            r_state <= S_DRAIN;
                            r_data  <= f_fmt(bus.res_in1);
                            r_valid <= 1'b1;
                            r_last  <= (bus.col_x == 2'd1);
                        end else begin
                            r_state <= S_COLLECT;
                        end
                    end
                end
                S_COLLECT: begin
                    if (bus.res_valid) begin
                        r_store[w_wbase]        <= bus.res_in1;
                        r_store[w_wbase + 4'd1] <= bus.res_in2;
                        r_store[w_wbase + 4'd2] <= bus.res_in3;
                        r_rc                    <= r_rc + 2'd1;
                        if (r_rc == r_rows - 2'd1) begin
                            // At least two rows, so (0,0) is never last here.
                            r_state <= S_DRAIN;
                            r_data  <= f_fmt(r_store[0]);
                            r_valid <= 1'b1;
                            r_last  <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.res_valid) r_ovf <= 1'b1;
                    if (w_hs) begin
                        if (r_last) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_ri   <= w_nri;
                            r_ci   <= w_nci;
                            r_data <= f_fmt(r_store[w_naddr]);
                            r_last <= w_nlast;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.res_valid) r_ovf <= 1'b1;
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_rc    <= 2'd0;
                    r_ri    <= 2'd0;
                    r_ci    <= 2'd0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.data_out   = r_data;
    assign bus.data_valid = r_valid;
    assign bus.last       = r_last;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.ovf        = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_result_bank.sv
// ============================================================================
//  Module      : tb_result_bank
//  Description : Directed self-checking bench for result_bank. Expected
//                drain elements are queued when rows are driven and popped
//                as each handshake occurs.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_result_bank;

    localparam int RES_W = 10;
    localparam int OUT_W = 8;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [RES_W-1:0] mdl [0:8];
    logic [OUT_W:0]   sb [$];

    result_bank_if #(.RES_W(RES_W), .OUT_W(OUT_W)) bus ();

    result_bank #(.RES_W(RES_W), .OUT_W(OUT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [OUT_W-1:0] fmt(input logic [RES_W-1:0] v);
`ifdef RESULT_BANK_SAT_EN
        return (v > 10'h0FF) ? 8'hFF : v[OUT_W-1:0];
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one result row for a single cycle (valid deasserted by the caller's next step).
    task automatic push_row(input int idx, input logic [RES_W-1:0] a, input logic [RES_W-1:0] b,
                            input logic [RES_W-1:0] c, input logic [1:0] rw, input logic [1:0] cx);
        @(negedge clk);
        bus.res_in1   = a;
        bus.res_in2   = b;
        bus.res_in3   = c;
        bus.row_w     = rw;
        bus.col_x     = cx;
        bus.res_valid = 1'b1;
        mdl[idx*3]   = a;
        mdl[idx*3+1] = b;
        mdl[idx*3+2] = c;
    endtask

    task automatic sb_load(input int nr, input int nc);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                sb.push_back({(r == nr-1 && c == nc-1), fmt(mdl[r*3+c])});
    endtask

    // Drain the queued elements; pat bit i is out_ready in drain cycle i,
    // inj_cyc is the drain cycle in which a stray res_valid is driven.
    task automatic drain(input logic [15:0] pat, input int inj_cyc);
        int               cyc;
        logic             stalled;
        logic [OUT_W-1:0] sd;
        logic             sl;
        logic [OUT_W:0]   e;
        cyc = 0;
        stalled = 1'b0;
        sd = '0;
        sl = 1'b0;
        while (sb.size() > 0 && cyc < 40) begin
            @(negedge clk);
            bus.res_valid = (cyc == inj_cyc);
            bus.res_in1   = 10'h077;
            bus.res_in2   = 10'h077;
            bus.res_in3   = 10'h077;
            bus.out_ready = (cyc < 16) ? pat[cyc] : 1'b1;
            if (!bus.data_valid) chk("valid_in_drain", bus.data_valid, 1);
            if (stalled) begin
                chk("stall_data", bus.data_out, sd);
                chk("stall_last", bus.last, sl);
            end
            if (bus.data_valid && bus.out_ready) begin
                e = sb.pop_front();
                chk("drain_data", bus.data_out, e[OUT_W-1:0]);
                chk("drain_last", bus.last, e[OUT_W]);
                stalled = 1'b0;
            end else if (bus.data_valid) begin
                stalled = 1'b1;
                sd = bus.data_out;
                sl = bus.last;
            end
            cyc++;
        end
        if (sb.size() > 0) begin
            chk("drain_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
        bus.res_valid = 1'b0;
        bus.out_ready = 1'b1;
        chk("done_pulse", bus.done, 1);
        chk("done_valid", bus.data_valid, 0);
        chk("done_busy", bus.busy, 1);
        @(negedge clk);
        chk("done_clear", bus.done, 0);
        chk("busy_fall", bus.busy, 0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        bus.res_in1 = '0; bus.res_in2 = '0; bus.res_in3 = '0;
        bus.res_valid = 1'b0; bus.row_w = 2'd0; bus.col_x = 2'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data", bus.data_out, 0);
        chk("rst_valid", bus.data_valid, 0);
        chk("rst_last", bus.last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_ovf", bus.ovf, 0);

        // Zero dimension beat is ignored.
        push_row(0, 10'd5, 10'd5, 10'd5, 2'd0, 2'd3);
        @(negedge clk);
        bus.res_valid = 1'b0;
        chk("zero_dim_busy", bus.busy, 0);
        chk("zero_dim_ovf", bus.ovf, 0);

        // 3x3 full drain, one element per cycle.
        push_row(0, 10'd1, 10'd2, 10'd3, 2'd3, 2'd3);
        push_row(1, 10'd4, 10'd5, 10'd6, 2'd0, 2'd0);
        push_row(2, 10'd7, 10'd8, 10'd9, 2'd0, 2'd0);
        sb_load(3, 3);
        drain(16'hFFFF, -1);

        // 2x1: unused lanes never appear.
        push_row(0, 10'd10, 10'd99, 10'd99, 2'd2, 2'd1);
        push_row(1, 10'd20, 10'd99, 10'd99, 2'd2, 2'd1);
        sb_load(2, 1);
        drain(16'hFFFF, -1);

        // 2x2 with back-pressure 1,0,0,1,1,0,1.
        push_row(0, 10'd11, 10'd12, 10'd55, 2'd2, 2'd2);
        push_row(1, 10'd13, 10'd14, 10'd55, 2'd2, 2'd2);
        sb_load(2, 2);
        drain(16'hFFD9, -1);

        // Stray beat during drain sets sticky ovf.
        push_row(0, 10'd5, 10'd6, 10'd7, 2'd1, 2'd3);
        sb_load(1, 3);
        drain(16'hFFFF, 1);
        chk("ovf_set", bus.ovf, 1);
        push_row(0, 10'd33, 10'd0, 10'd0, 2'd1, 2'd1);
        sb_load(1, 1);
        drain(16'hFFFF, -1);
        chk("ovf_sticky", bus.ovf, 1);

        // Entries wider than the output.
        push_row(0, 10'h3FF, 10'h1A5, 10'h0, 2'd1, 2'd2);
        sb_load(1, 2);
        drain(16'hFFFF, -1);

        // Reset mid-collect, then a fresh 1x1 run.
        push_row(0, 10'd1, 10'd2, 10'd3, 2'd3, 2'd3);
        @(negedge clk);
        bus.res_valid = 1'b0;
        chk("collect_busy", bus.busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_valid", bus.data_valid, 0);
        chk("mid_rst_ovf", bus.ovf, 0);
        chk("mid_rst_data", bus.data_out, 0);
        push_row(0, 10'd42, 10'd0, 10'd0, 2'd1, 2'd1);
        sb_load(1, 1);
        drain(16'hFFFF, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
